gost_round_engine: RTL and testbench

GOST_ROUND_ENGINE -- requirements
Module: gost_round_engine

---
 rtl/gost_round_engine.sv | 117 +++++++++++
 tb/tb_gost_round_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost_round_engine.sv
// Iterative GOST 28147-89 round engine: one Feistel round per clock over 32 rounds,
// with the S-box substitution stage supplied externally through subst_in/subst_out.
module gost_round_engine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [255:0] key,
    input  logic [63:0]  data_in,
    output logic [31:0]  subst_in,
    input  logic [31:0]  subst_out,
    output logic         busy,
    output logic         done,
    output logic [63:0]  data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [255:0]  key_q, key_d;
    logic [31:0]   n1_q, n1_d;
    logic [31:0]   n2_q, n2_d;
    logic [63:0]   data_out_q, data_out_d;

    logic [31:0]   key_word [8];
    logic          reverse_order;
    logic [2:0]    ksel_idx;
    logic [31:0]   ksel;
    logic [31:0]   f_val;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key_word
            assign key_word[gi] = key_q[32*gi +: 32];
        end
    endgenerate

    // Encrypt walks K0..K7 three times then K7..K0; decrypt does K0..K7 once then K7..K0 three times.
    // 7 - (cnt mod 8) is simply the bitwise inverse of cnt[2:0].
    assign reverse_order = mode_q ? (cnt_q >= 5'd8) : (cnt_q >= 5'd24);
    assign ksel_idx      = reverse_order ? ~cnt_q[2:0] : cnt_q[2:0];
    assign ksel          = key_word[ksel_idx];

    assign subst_in = (state_q == RUN) ? (n1_q + ksel) : 32'h0;
    assign f_val    = {subst_out[20:0], subst_out[31:21]};

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = data_out_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        key_d      = key_q;
        n1_d       = n1_q;
        n2_d       = n2_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    mode_d  = mode;
                    key_d   = key;
                    n1_d    = data_in[31:0];
                    n2_d    = data_in[63:32];
                end
            end
            RUN: begin
                if (cnt_q == 5'd31) begin
                    // Final round keeps the halves in place.
                    n2_d       = n2_q ^ f_val;
                    data_out_d = {n2_q ^ f_val, n1_q};
                    state_d    = DONE;
                end else begin
                    n1_d  = n2_q ^ f_val;
                    n2_d  = n1_q;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            mode_q     <= 1'b0;
            key_q      <= 256'h0;
            n1_q       <= 32'h0;
            n2_q       <= 32'h0;
            data_out_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            key_q      <= key_d;
            n1_q       <= n1_d;
            n2_q       <= n2_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_gost_round_engine.sv
// Self-checking bench for gost_round_engine: supplies a behavioural S-box, predicts
// every round's subst_in and each result via a scoreboard, and exercises timing corners.
module tb_gost_round_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [255:0] key = '0;
    logic [63:0]  data_in = '0;
    logic [31:0]  subst_in;
    logic [31:0]  subst_out;
    logic         busy;
    logic         done;
    logic [63:0]  data_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gost_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .key       (key),
        .data_in   (data_in),
        .subst_in  (subst_in),
        .subst_out (subst_out),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    // Row i maps nibble i of the input; entry n sits at bits [4n+3:4n].
    logic [63:0] sbox_rows [8] = '{
        64'h4A92D80E6B1C7F53, 64'hEB4C8D7A21F59306, 64'h581DA342EFC7609B,
        64'h7DA1089FE46CB253, 64'h6C715FD84A9E03B2, 64'h4BA0721D36859CFE,
        64'hDB413F590AE7C286, 64'h1FD057A4923E6B8C
    };

    function automatic logic [31:0] sbox_f(input logic [31:0] x);
        logic [31:0] y;
        int n;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            n = int'(x[4*i +: 4]);
            y[4*i +: 4] = sbox_rows[i][4*n +: 4];
        end
        return y;
    endfunction

    assign subst_out = sbox_f(subst_in);

    logic [31:0] exp_sub_q [$];
    logic [63:0] exp_res_q [$];
    int          model_cnt = 0;
    int          cycle_no = 0;

    function automatic logic [63:0] gost_model(input logic m, input logic [255:0] k,
                                               input logic [63:0] d, input bit record);
        logic [31:0] n1, n2, s, t, f, tmp;
        int kidx;
        n1 = d[31:0];
        n2 = d[63:32];
        for (int r = 0; r < 32; r++) begin
            if (!m) kidx = (r < 24) ? (r % 8) : (7 - (r % 8));
            else    kidx = (r < 8)  ? (r % 8) : (7 - (r % 8));
            s = n1 + k[32*kidx +: 32];
            if (record) exp_sub_q.push_back(s);
            t = sbox_f(s);
            f = {t[20:0], t[31:21]};
            if (r < 31) begin
                tmp = n1;
                n1  = n2 ^ f;
                n2  = tmp;
            end else begin
                n2 = n2 ^ f;
            end
        end
        return {n2, n1};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // Reference timing: model_cnt = 33 in the first RUN cycle, 1 in the DONE cycle, 0 when idle.
    always @(posedge clk) begin
        cycle_no++;
        if (!rst_n) begin
            model_cnt = 0;
            exp_sub_q.delete();
            exp_res_q.delete();
        end else if (model_cnt == 0) begin
            if (start) begin
                exp_res_q.push_back(gost_model(mode, key, data_in, 1'b1));
                model_cnt = 33;
            end
        end else begin
            model_cnt--;
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_s;
        logic [63:0] exp_r;
        tests_run++;
        if (busy !== (model_cnt > 0)) begin
            tests_failed++;
            $display("[TB] FAIL busy: got %b expected %b at cycle %0d", busy, model_cnt > 0, cycle_no);
        end
        tests_run++;
        if (done !== (model_cnt == 1)) begin
            tests_failed++;
            $display("[TB] FAIL done: got %b expected %b at cycle %0d", done, model_cnt == 1, cycle_no);
        end
        exp_s = 32'h0;
        if (model_cnt >= 2) begin
            if (exp_sub_q.size() > 0) exp_s = exp_sub_q.pop_front();
            else exp_s = 32'hxxxxxxxx;
        end
        tests_run++;
        if (subst_in !== exp_s) begin
            tests_failed++;
            $display("[TB] FAIL subst_in: got %h expected %h at cycle %0d", subst_in, exp_s, cycle_no);
        end
        if (model_cnt == 1) begin
            exp_r = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 64'hxxxxxxxxxxxxxxxx;
            tests_run++;
            if (data_out !== exp_r) begin
                tests_failed++;
                $display("[TB] FAIL result: got %h expected %h", data_out, exp_r);
            end else begin
                $display("[TB] op complete at cycle %0d data_out=%h", cycle_no, data_out);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (model_cnt != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (model_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL idle_timeout: model_cnt %0d expected 0", model_cnt);
        end
        @(negedge clk);
    endtask

    task automatic do_op(input logic m, input logic [255:0] k, input logic [63:0] d,
                         output logic [63:0] res);
        int n;
        wait_idle();
        mode = m; key = k; data_in = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL done_timeout: done %b expected 1", done);
        end
        res = data_out;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 4;
        if (busy !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (data_out !== '0)  begin tests_failed++; $display("[TB] FAIL reset_data_out: got %h expected 0", data_out); end
        if (subst_in !== '0)  begin tests_failed++; $display("[TB] FAIL reset_subst_in: got %h expected 0", subst_in); end
        key = rand_key(); data_in = {$urandom, $urandom}; mode = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_start: busy %b expected 1", busy);
        end
        wait_idle();
    endtask

    task automatic test_latency();
        logic [63:0] golden;
        golden = gost_model(1'b0, '0, '0, 1'b0);
        mode = 1'b0; key = '0; data_in = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tests_run += 2;
            if (busy !== (k <= 33)) begin
                tests_failed++;
                $display("[TB] FAIL latency_busy: cycle E+%0d got %b expected %b", k, busy, k <= 33);
            end
            if (done !== (k == 33)) begin
                tests_failed++;
                $display("[TB] FAIL latency_done: cycle E+%0d got %b expected %b", k, done, k == 33);
            end
            if (k == 33) begin
                tests_run++;
                if (data_out !== golden) begin
                    tests_failed++;
                    $display("[TB] FAIL latency_golden: got %h expected %h", data_out, golden);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_trip();
        logic [255:0] k;
        logic [63:0]  ct, pt;
        k = 256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;
        do_op(1'b0, k, 64'hFEDCBA9876543210, ct);
        tests_run++;
        if (ct === 64'hFEDCBA9876543210) begin
            tests_failed++;
            $display("[TB] FAIL encrypt_changes: got %h expected anything else", ct);
        end
        do_op(1'b1, k, ct, pt);
        tests_run++;
        if (pt !== 64'hFEDCBA9876543210) begin
            tests_failed++;
            $display("[TB] FAIL round_trip: got %h expected fedcba9876543210", pt);
        end
    endtask

    task automatic test_key_order();
        logic [255:0] k;
        logic [63:0]  d, res, exp;
        for (int m = 0; m < 2; m++) begin
            k = rand_key();
            d = {$urandom, $urandom};
            exp = gost_model(m[0], k, d, 1'b0);
            do_op(m[0], k, d, res);
            tests_run++;
            if (res !== exp) begin
                tests_failed++;
                $display("[TB] FAIL key_order_mode%0d: got %h expected %h", m, res, exp);
            end
        end
    endtask

    task automatic test_busy_latch();
        logic [255:0] k;
        logic [63:0]  d, exp;
        int done_cnt;
        wait_idle();
        k = rand_key(); d = {$urandom, $urandom};
        exp = gost_model(1'b0, k, d, 1'b0);
        mode = 1'b0; key = k; data_in = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 72; c++) begin
            if (done) begin
                done_cnt++;
                tests_run++;
                if (c != 33 || data_out !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL latch_result: cycle E+%0d data %h expected E+33 data %h", c, data_out, exp);
                end
            end
            if (c == 5)  begin start = 1'b1; data_in = ~d; end
            if (c == 6)  start = 1'b0;
            if (c == 10) begin key = ~k; data_in = d ^ 64'h5555; mode = 1'b1; end
            if (c == 33) start = 1'b1;
            if (c == 34) start = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL latch_single_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] res, exp;
        int done_cnt;
        wait_idle();
        key = rand_key(); data_in = {$urandom, $urandom}; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run += 2;
        if (busy !== 1'b0)   begin tests_failed++; $display("[TB] FAIL midrun_busy: got %b expected 0", busy); end
        if (data_out !== '0) begin tests_failed++; $display("[TB] FAIL midrun_data_out: got %h expected 0", data_out); end
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        tests_run += 2;
        if (done_cnt != 0)   begin tests_failed++; $display("[TB] FAIL midrun_no_done: got %0d expected 0", done_cnt); end
        if (data_out !== '0) begin tests_failed++; $display("[TB] FAIL midrun_hold: got %h expected 0", data_out); end
        key = rand_key();
        exp = gost_model(1'b1, key, 64'h0123456789ABCDEF, 1'b0);
        do_op(1'b1, key, 64'h0123456789ABCDEF, res);
        tests_run++;
        if (res !== exp) begin
            tests_failed++;
            $display("[TB] FAIL midrun_restart: got %h expected %h", res, exp);
        end
    endtask

    task automatic test_back_to_back();
        int done_at [$];
        wait_idle();
        key = rand_key(); data_in = {$urandom, $urandom}; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 140; c++) begin
            if (done) done_at.push_back(c);
            if (c == 100) start = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (done_at.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", done_at.size());
        end
        for (int i = 1; i < done_at.size(); i++) begin
            tests_run++;
            if (done_at[i] - done_at[i-1] != 34) begin
                tests_failed++;
                $display("[TB] FAIL b2b_spacing: got %0d expected 34", done_at[i] - done_at[i-1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_round_trip();
        test_key_order();
        test_busy_latch();
        test_reset_midrun();
        test_back_to_back();
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
